// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of io_in; optional sticky overflow under PWM_CAPTURE_OVF_EN.
// Latency: result (io_high/io_period/io_valid) visible the cycle after the rise that terminates a period.
// Backpressure: io_valid/io_ready handshake; a result completing while one is still held overwrites it.
module pwm_capture (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_en,
    input  logic       io_in,
    output logic [7:0] io_high,
    output logic [8:0] io_period,
    output logic       io_valid,
    input  logic       io_ready,
    output logic       io_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        in_q;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [7:0]  lcnt_q, lcnt_d;
    logic [7:0]  high_q, high_d;
    logic [8:0]  period_q, period_d;
    logic        valid_q, valid_d;
    logic        rise, fall;
    logic        done;
    logic        consume;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rise    = io_in && !in_q;
    assign fall    = !io_in && in_q;
    assign consume = valid_q && io_ready;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        done    = 1'b0;
        if (!io_en) begin
            state_d = IDLE;
            hcnt_d  = 8'd0;
            lcnt_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        hcnt_d  = 8'd1;
                        lcnt_d  = 8'd0;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (io_in) begin
                        hcnt_d = sat_inc(hcnt_q);
                    end else if (fall) begin
                        lcnt_d  = 8'd1;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        // Terminating rise doubles as the start of the next period.
                        done    = 1'b1;
                        hcnt_d  = 8'd1;
                        lcnt_d  = 8'd0;
                        state_d = HIGH;
                    end else if (!io_in) begin
                        lcnt_d = sat_inc(lcnt_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                    hcnt_d  = 8'd0;
                    lcnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        high_d   = high_q;
        period_d = period_q;
        valid_d  = valid_q;
        if (done) begin
            high_d   = hcnt_q;
            period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
            valid_d  = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            in_q     <= 1'b0;
            hcnt_q   <= 8'd0;
            lcnt_q   <= 8'd0;
            high_q   <= 8'd0;
            period_q <= 9'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_q     <= io_in;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end

`ifdef PWM_CAPTURE_OVF_EN
    logic ovf_q;
    logic overwrite;
    logic sat_hit;

    assign overwrite = done && valid_q && !io_ready;
    assign sat_hit   = (hcnt_d == 8'hFF) || (lcnt_d == 8'hFF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (overwrite || sat_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign io_overflow = ovf_q;
`else
    assign io_overflow = 1'b0;
`endif

    assign io_high   = high_q;
    assign io_period = period_q;
    assign io_valid  = valid_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a timestamp-based model pushes expected results, a negedge monitor pops on handshake.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       io_en;
    logic       io_in;
    logic [7:0] io_high;
    logic [8:0] io_period;
    logic       io_valid;
    logic       io_ready;
    logic       io_overflow;

    pwm_capture dut (
        .clock      (clock),
        .reset      (reset),
        .io_en      (io_en),
        .io_in      (io_in),
        .io_high    (io_high),
        .io_period  (io_period),
        .io_valid   (io_valid),
        .io_ready   (io_ready),
        .io_overflow(io_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] h;
        logic [8:0] p;
    } res_t;

    int   nvec = 0;
    int   nerr = 0;
    res_t exp_q[$];
    res_t mon_r;

    // Reference model: edge timestamps rather than counters.
    int   m_t, m_rise_t, m_fall_t;
    bit   m_armed, m_fell, m_in_prev, m_pending, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_t = 0; m_rise_t = 0; m_fall_t = 0;
        m_armed = 0; m_fell = 0; m_in_prev = 0; m_pending = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic in_v, input logic en_v, input logic rdy_v);
        bit   rise, fall, consume, complete;
        int   h, l, run;
        res_t r;
        rise     = in_v && !m_in_prev;
        fall     = !in_v && m_in_prev;
        consume  = m_pending && rdy_v;
        complete = 0;
        r        = '0;
        m_t++;
        if (!en_v) begin
            m_armed = 0;
            m_fell  = 0;
        end else if (rise) begin
            if (m_armed && m_fell) begin
                h = m_fall_t - m_rise_t;
                l = m_t - m_fall_t;
                if (h > 255) h = 255;
                if (l > 255) l = 255;
                r.h = 8'(h);
                r.p = 9'(h + l);
                complete = 1;
            end
            m_armed  = 1;
            m_fell   = 0;
            m_rise_t = m_t;
        end else if (fall && m_armed) begin
            m_fell   = 1;
            m_fall_t = m_t;
        end else if (m_armed) begin
            run = m_fell ? (m_t - m_fall_t + 1) : (m_t - m_rise_t + 1);
            if (run >= 255 && OVF_EN) m_ovf = 1;
        end
        if (complete) begin
            if (m_pending && !consume) begin
                exp_q.delete(exp_q.size() - 1);
                if (OVF_EN) m_ovf = 1;
            end
            exp_q.push_back(r);
            m_pending = 1;
        end else if (consume) begin
            m_pending = 0;
        end
        m_in_prev = in_v;
    endtask

    task automatic step(input logic in_v, input logic en_v, input logic rdy_v);
        io_in    = in_v;
        io_en    = en_v;
        io_ready = rdy_v;
        @(posedge clock);
        model_edge(in_v, en_v, rdy_v);
        #1;
    endtask

    task automatic hold(input logic in_v, input int n, input logic en_v, input logic rdy_v);
        for (int i = 0; i < n; i++) step(in_v, en_v, rdy_v);
    endtask

    // Called just after an edge; reset asserts and releases between edges.
    task automatic pulse_reset(input string name);
        #3 reset = 1'b0;
        #1;
        chk({name, "_high0"},   32'(io_high),     32'd0);
        chk({name, "_period0"}, 32'(io_period),   32'd0);
        chk({name, "_valid0"},  32'(io_valid),    32'd0);
        chk({name, "_ovf0"},    32'(io_overflow), 32'd0);
        model_reset();
        #3 reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            chk("valid", 32'(io_valid), 32'(m_pending));
            chk("overflow", 32'(io_overflow), 32'(m_ovf));
            if (io_valid === 1'b1 && io_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(io_valid), 32'd0);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("res_high",   32'(io_high),   32'(mon_r.h));
                    chk("res_period", 32'(io_period), 32'(mon_r.p));
                end
            end
        end
    end

    initial begin
        int   hl, ll;
        logic en_r, rdy_r;
        reset = 1'b0; io_en = 1'b0; io_in = 1'b0; io_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_high",   32'(io_high),     32'd0);
        chk("rst_period", 32'(io_period),   32'd0);
        chk("rst_valid",  32'(io_valid),    32'd0);
        chk("rst_ovf",    32'(io_overflow), 32'd0);
        #6 reset = 1'b1;

        // Steady 6-high / 5-low waveform, consumer always ready.
        hold(1'b0, 3, 1'b1, 1'b1);
        repeat (3) begin
            hold(1'b1, 6, 1'b1, 1'b1);
            hold(1'b0, 5, 1'b1, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1);
        chk("r026_valid",  32'(io_valid),  32'd1);
        chk("r026_high",   32'(io_high),   32'd6);
        chk("r026_period", 32'(io_period), 32'd11);

        // Reset in the middle of a LOW phase.
        hold(1'b1, 5, 1'b1, 1'b1);
        hold(1'b0, 2, 1'b1, 1'b1);
        pulse_reset("r030");
        hold(1'b0, 2, 1'b1, 1'b1);
        hold(1'b1, 3, 1'b1, 1'b1);
        hold(1'b0, 3, 1'b1, 1'b1);
        chk("r030_nores", 32'(io_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1);
        chk("r030_valid",  32'(io_valid),  32'd1);
        chk("r030_period", 32'(io_period), 32'd6);

        // Two periods with no consumer: second overwrites first.
        hold(1'b0, 2, 1'b0, 1'b1);
        hold(1'b0, 2, 1'b1, 1'b0);
        hold(1'b1, 2, 1'b1, 1'b0);
        hold(1'b0, 3, 1'b1, 1'b0);
        hold(1'b1, 4, 1'b1, 1'b0);
        hold(1'b0, 1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("r027_high",   32'(io_high),     32'd4);
        chk("r027_period", 32'(io_period),   32'd5);
        chk("r027_valid",  32'(io_valid),    32'd1);
        chk("r027_ovf",    32'(io_overflow), 32'(OVF_EN));

        // Long high phase saturates the high counter.
        pulse_reset("r028");
        hold(1'b0, 1, 1'b1, 1'b1);
        hold(1'b1, 300, 1'b1, 1'b1);
        hold(1'b0, 2, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("r028_high",   32'(io_high),     32'd255);
        chk("r028_period", 32'(io_period),   32'd257);
        chk("r028_ovf",    32'(io_overflow), 32'(OVF_EN));

        // Enable dropped for one cycle mid-HIGH while a result is held.
        hold(1'b0, 2, 1'b0, 1'b1);
        hold(1'b0, 1, 1'b1, 1'b0);
        hold(1'b1, 3, 1'b1, 1'b0);
        hold(1'b0, 3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        hold(1'b1, 1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        hold(1'b1, 2, 1'b1, 1'b0);
        hold(1'b0, 2, 1'b1, 1'b0);
        hold(1'b1, 2, 1'b1, 1'b0);
        hold(1'b0, 2, 1'b1, 1'b0);
        chk("r029_hold_high",   32'(io_high),   32'd3);
        chk("r029_hold_period", 32'(io_period), 32'd6);
        chk("r029_hold_valid",  32'(io_valid),  32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("r029_new_high",   32'(io_high),   32'd2);
        chk("r029_new_period", 32'(io_period), 32'd4);

        // Consume and new completion on the same edge.
        pulse_reset("r031");
        hold(1'b0, 1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (4) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1);
        end
        chk("r031_valid",  32'(io_valid),    32'd1);
        chk("r031_high",   32'(io_high),     32'd1);
        chk("r031_period", 32'(io_period),   32'd2);
        chk("r031_ovf",    32'(io_overflow), 32'd0);

        // Randomized waveforms, backpressure, enable drops and resets.
        for (int s = 0; s < 220; s++) begin
            hl = ($urandom_range(0, 29) == 0) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 10));
            ll = ($urandom_range(0, 29) == 0) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 10));
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
            for (int i = 0; i < hl + ll; i++) begin
                en_r  = ($urandom_range(0, 99) != 0);
                rdy_r = ($urandom_range(0, 3) != 0);
                step((i < hl) ? 1'b1 : 1'b0, en_r, rdy_r);
            end
        end

        hold(1'b0, 3, 1'b1, 1'b1);
        chk("drain_valid", 32'(io_valid), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
